// File: rtl/gpr_wport_arb_pkg.sv
// Shared definitions for the GPR write-port arbiter: FSM state encodings,
// the hard-wired zero register and the queue entry layout.
package gpr_wport_arb_pkg;

    localparam int A3_W = 5;
    localparam int WD_W = 32;

    localparam logic [A3_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PEND  = 2'd1,
        S_FORCE = 2'd2
    } arb_state_e;

    // Payload of one queued MDU result; the live bit is kept per entry beside it
    typedef struct packed {
        logic [A3_W-1:0] a3;
        logic [WD_W-1:0] wd;
    } wq_data_t;

endpackage

// File: rtl/gpr_wport_arb_wq.sv
// MDU result queue for the GPR write-port arbiter.
// DEPTH-entry FIFO where every entry carries a live bit. A kill port clears the
// live bit of every entry whose destination matches; dead entries still occupy
// their slot until popped. Two query ports report hits on live entries only.
module gpr_wport_arb_wq
    import gpr_wport_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            srst,
    input  logic            i_push,
    input  logic [A3_W-1:0] i_push_a3,
    input  logic [WD_W-1:0] i_push_wd,
    input  logic            i_pop,
    input  logic            i_kill_en,
    input  logic [A3_W-1:0] i_kill_a3,
    input  logic [A3_W-1:0] i_q_a1,
    input  logic [A3_W-1:0] i_q_a2,
    output logic            o_hit1,
    output logic            o_hit2,
    output logic            o_head_live,
    output logic [A3_W-1:0] o_head_a3,
    output logic [WD_W-1:0] o_head_wd,
    output logic            o_last,
    output logic            o_full,
    output logic            o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [DEPTH-1:0] w_live;
    logic [DEPTH-1:0] w_hit1_vec;
    logic [DEPTH-1:0] w_hit2_vec;
    wq_data_t         r_data [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic r_live_e;
            logic w_push_here;
            logic w_pop_here;
            logic w_kill_here;

            assign w_push_here = i_push && (r_wr_ptr == PTR_W'(gi));
            assign w_pop_here  = i_pop  && (r_rd_ptr == PTR_W'(gi));
            assign w_kill_here = i_kill_en && (r_data[gi].a3 == i_kill_a3);

            // Live bit: set by a push to a non-zero register (a same-cycle kill
            // targets older entries only), cleared by pop or by a younger WB write
            always_ff @(posedge clk) begin
                if (srst) begin
                    r_live_e <= 1'b0;
                end else if (w_push_here) begin
                    r_live_e <= (i_push_a3 != REG_ZERO);
                end else if (w_pop_here || w_kill_here) begin
                    r_live_e <= 1'b0;
                end
            end

            assign w_live[gi]     = r_live_e;
            assign w_hit1_vec[gi] = r_live_e && (r_data[gi].a3 == i_q_a1);
            assign w_hit2_vec[gi] = r_live_e && (r_data[gi].a3 == i_q_a2);
        end
    endgenerate

    // Payload storage, written at the tail on every accepted push
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_data[r_wr_ptr] <= '{a3: i_push_a3, wd: i_push_wd};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (i_pop && !i_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    assign o_head_live = w_live[r_rd_ptr];
    assign o_head_a3   = r_data[r_rd_ptr].a3;
    assign o_head_wd   = r_data[r_rd_ptr].wd;
    assign o_hit1      = (i_q_a1 != REG_ZERO) && (|w_hit1_vec);
    assign o_hit2      = (i_q_a2 != REG_ZERO) && (|w_hit2_vec);
    assign o_last      = (r_count == CNT_W'(1));
    assign o_full      = (r_count == CNT_W'(DEPTH));
    assign o_empty     = (r_count == CNT_W'(0));

endmodule

// File: rtl/gpr_wport_arb.sv
// Arbiter for the single GPR write port, shared by pipeline writeback (WB) and
// the multi-cycle mult/div unit (MDU). WB always wins with zero latency; MDU
// results wait in a small queue and drain into WB-idle cycles.
// Optional starvation guard: define GPR_ARB_STARVE_EN to build the age counter
// and the S_FORCE state that requests a pipeline bubble for an old head.
module gpr_wport_arb
    import gpr_wport_arb_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            WB_WE,
    input  logic [A3_W-1:0] WB_A3,
    input  logic [WD_W-1:0] WB_WD,
    input  logic            MD_Valid,
    input  logic [A3_W-1:0] MD_A3,
    input  logic [WD_W-1:0] MD_WD,
    output logic            MD_Ready,
    input  logic [A3_W-1:0] Q_A1,
    input  logic [A3_W-1:0] Q_A2,
    output logic            Q_Hit1,
    output logic            Q_Hit2,
    output logic            Stall_Req,
    output logic            GPR_WE,
    output logic [A3_W-1:0] GPR_A3,
    output logic [WD_W-1:0] GPR_WD,
    output logic            Full,
    output logic            Empty
);

    logic            w_wb_go;
    logic            w_push;
    logic            w_pop;
    logic            w_drain;
    logic            w_empty_next;
    logic            w_head_live;
    logic [A3_W-1:0] w_head_a3;
    logic [WD_W-1:0] w_head_wd;
    logic            w_hit1;
    logic            w_hit2;
    logic            w_last;
    logic            w_full;
    logic            w_empty;

    arb_state_e      r_state;

    // A WB request to $0 is treated as an idle cycle so the queue can drain
    assign w_wb_go = WB_WE && (WB_A3 != REG_ZERO);

    // Acceptance depends on registered occupancy only; no push-through when full
    assign MD_Ready = !w_full && !Reset;
    assign w_push   = MD_Valid && MD_Ready;

    // Head writes only in a WB-free cycle; a dead head leaves without using the port
    assign w_drain      = !Reset && w_head_live && !w_wb_go;
    assign w_pop        = !Reset && !w_empty && (!w_head_live || !w_wb_go);
    assign w_empty_next = w_pop && !w_push && w_last;

    gpr_wport_arb_wq #(
        .DEPTH (DEPTH)
    ) u_wq (
        .clk         (Clk),
        .srst        (Reset),
        .i_push      (w_push),
        .i_push_a3   (MD_A3),
        .i_push_wd   (MD_WD),
        .i_pop       (w_pop),
        .i_kill_en   (w_wb_go && !Reset),
        .i_kill_a3   (WB_A3),
        .i_q_a1      (Q_A1),
        .i_q_a2      (Q_A2),
        .o_hit1      (w_hit1),
        .o_hit2      (w_hit2),
        .o_head_live (w_head_live),
        .o_head_a3   (w_head_a3),
        .o_head_wd   (w_head_wd),
        .o_last      (w_last),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // Zero-latency grant mux driving the register-file write port
    always_comb begin
        GPR_WE = 1'b0;
        GPR_A3 = REG_ZERO;
        GPR_WD = '0;
        if (!Reset && w_wb_go) begin
            GPR_WE = 1'b1;
            GPR_A3 = WB_A3;
            GPR_WD = WB_WD;
        end else if (w_drain) begin
            GPR_WE = 1'b1;
            GPR_A3 = w_head_a3;
            GPR_WD = w_head_wd;
        end
    end

    assign Q_Hit1 = w_hit1 && !Reset;
    assign Q_Hit2 = w_hit2 && !Reset;
    assign Full   = w_full;
    assign Empty  = w_empty;

`ifdef GPR_ARB_STARVE_EN
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

    logic [AGE_W-1:0] r_age;
    logic [AGE_W-1:0] w_age_inc;
    logic             r_stall;

    assign w_age_inc = (r_age == '1) ? r_age : (r_age + AGE_W'(1));
    assign Stall_Req = r_stall && !Reset;

    // Queue-state FSM with head age tracking and registered bubble request
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_age   <= '0;
            r_stall <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_push) begin
                        r_state <= S_PEND;
                        r_age   <= '0;
                    end
                end
                S_PEND: begin
                    if (w_pop) begin
                        r_age <= '0;
                        if (w_empty_next) begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_age <= w_age_inc;
                        if (w_age_inc == AGE_W'(STARVE_LIMIT - 1)) begin
                            r_state <= S_FORCE;
                            r_stall <= 1'b1;
                        end
                    end
                end
                S_FORCE: begin
                    // A WB write here still wins; only the head leaving ends the bubble request
                    if (w_pop) begin
                        r_age   <= '0;
                        r_stall <= 1'b0;
                        r_state <= w_empty_next ? S_IDLE : S_PEND;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_age   <= '0;
                    r_stall <= 1'b0;
                end
            endcase
        end
    end
`else
    assign Stall_Req = 1'b0;

    // The starvation limit only matters when the guard is built in
    generate
        if (STARVE_LIMIT < 1) begin : g_limit_unused
        end
    endgenerate

    // Queue-state FSM: tracks whether any entry is pending
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_push) begin
                        r_state <= S_PEND;
                    end
                end
                S_PEND: begin
                    if (w_empty_next) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
`endif

endmodule
